// File: rtl/key_geom_pkg.sv
// Shared key geometry for the piano display: note offsets, black-key map,
// key widths and the locator state type. Also used by the renderer.
package key_geom_pkg;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int NOTES     = 12;
  localparam int WHITE_W   = 22;
  localparam int BLACK_W   = 12;
  localparam int OFFSCREEN = 640;

  localparam logic [7:0] NOTE_OFS [NOTES] = '{
    8'd0, 8'd17, 8'd23, 8'd40, 8'd46, 8'd69,
    8'd85, 8'd92, 8'd109, 8'd115, 8'd132, 8'd137
  };

  localparam logic NOTE_BLACK [NOTES] = '{
    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0
  };

  function automatic logic [4:0] key_width(input logic black);
    return black ? 5'(BLACK_W) : 5'(WHITE_W);
  endfunction

endpackage

// File: rtl/note_geom_lut.sv
// Combinational note-in-octave lookup: remainder -> x offset, black flag, width.
module note_geom_lut
  import key_geom_pkg::*;
(
  input  logic [3:0] rem,
  output logic [7:0] ofs,
  output logic       black,
  output logic [4:0] width
);

  // Table lookup; out-of-table indices map to a white key at offset 0
  always_comb begin
    ofs   = '0;
    black = 1'b0;
    if (rem < 4'(NOTES)) begin
      ofs   = NOTE_OFS[rem];
      black = NOTE_BLACK[rem];
    end
    width = key_width(black);
  end

endmodule

// File: rtl/pitch_key_locator.sv
// Pitch-to-key mapper: accepts a transposed pitch, splits it into octave and
// note with an iterative subtract-12 divider and returns key geometry.
module pitch_key_locator
  import key_geom_pkg::*;
#(
  parameter int NUM_OCT   = 4,
  parameter int PITCH_W   = 6,
  parameter int TR_W      = 5,
  parameter int POS_W     = 10,
  parameter int X0        = 1,
  parameter int OCT_PITCH = 160
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PITCH_W-1:0] in_pitch,
  input  logic [TR_W-1:0]    in_trans,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [POS_W-1:0]   out_pos,
  output logic               out_black,
  output logic [4:0]         out_width,
  output logic               out_oor,
  output logic [2:0]         out_oct
);

  localparam int EW    = PITCH_W + 2;
  localparam int LEGAL = 12 * NUM_OCT;

  state_t               state, next;
  logic signed [EW-1:0] eff;
  logic                 eff_oor;
  logic [EW-1:0]        rem;
  logic [2:0]           oct_cnt;
  logic [7:0]           lut_ofs;
  logic                 lut_black;
  logic [4:0]           lut_width;

  note_geom_lut u_lut (
    .rem   (rem[3:0]),
    .ofs   (lut_ofs),
    .black (lut_black),
    .width (lut_width)
  );

  // Effective pitch and range test on the incoming request
  always_comb begin
    eff     = $signed({2'b00, in_pitch}) + EW'($signed(in_trans));
    eff_oor = eff[EW-1] || (int'(eff) >= LEGAL);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (in_valid) next = eff_oor ? DONE : DIV;
      DIV:     if (rem < EW'(12)) next = DONE;
      DONE:    if (out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Divider and result registers; results only load on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rem       <= '0;
      oct_cnt   <= '0;
      out_pos   <= POS_W'(OFFSCREEN);
      out_black <= 1'b0;
      out_width <= 5'(WHITE_W);
      out_oor   <= 1'b0;
      out_oct   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (eff_oor) begin
              out_pos   <= POS_W'(OFFSCREEN);
              out_black <= 1'b0;
              out_width <= 5'(WHITE_W);
              out_oor   <= 1'b1;
              out_oct   <= '0;
            end else begin
              rem     <= eff;
              oct_cnt <= '0;
            end
          end
        end
        DIV: begin
          if (rem >= EW'(12)) begin
            rem     <= rem - EW'(12);
            oct_cnt <= oct_cnt + 3'd1;
          end else begin
            out_pos   <= POS_W'(X0 + int'(oct_cnt) * OCT_PITCH + int'(lut_ofs));
            out_black <= lut_black;
            out_width <= lut_width;
            out_oor   <= 1'b0;
            out_oct   <= oct_cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_key_locator.sv
// Directed and randomized checks of pitch_key_locator against a plain
// arithmetic model of the keyboard geometry.
module tb_pitch_key_locator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [5:0] in_pitch;
  logic [4:0] in_trans;
  logic [9:0] out_pos;
  logic       out_black, out_oor;
  logic [4:0] out_width;
  logic [2:0] out_oct;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pitch_key_locator #(
    .NUM_OCT(4), .PITCH_W(6), .TR_W(5), .POS_W(10), .X0(1), .OCT_PITCH(160)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pitch(in_pitch), .in_trans(in_trans),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_black(out_black), .out_width(out_width),
    .out_oor(out_oor), .out_oct(out_oct)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Keyboard model: octave/note by integer division, offsets from the key layout
  function automatic void model(input int p, input int t,
                                output int pos, output int black, output int width,
                                output int oor, output int oct, output int lat);
    int ofs [12] = '{0, 17, 23, 40, 46, 69, 85, 92, 109, 115, 132, 137};
    int eff, note;
    eff = p + t;
    if (eff < 0 || eff >= 48) begin
      pos = 640; black = 0; width = 22; oor = 1; oct = 0; lat = 1;
    end else begin
      oct   = eff / 12;
      note  = eff % 12;
      black = (note == 1 || note == 3 || note == 6 || note == 8 || note == 10) ? 1 : 0;
      width = black ? 12 : 22;
      pos   = (1 + oct * 160 + ofs[note]) % 1024;
      oor   = 0;
      lat   = 2 + eff / 12;
    end
  endfunction

  // One full transaction: request, latency, result, hold cycles, release
  task automatic run_req(input int p, input int t, input int hold);
    int w, lat, e_pos, e_blk, e_w, e_oor, e_oct, e_lat;
    model(p, t, e_pos, e_blk, e_w, e_oor, e_oct, e_lat);
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    chk("in_ready_before_req", in_ready, 1);
    in_valid = 1'b1;
    in_pitch = 6'(p);
    in_trans = 5'(t);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_pitch = 6'($urandom);
    in_trans = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("latency", lat, e_lat);
    chk("out_valid", out_valid, 1);
    chk("pos", out_pos, e_pos);
    chk("black", out_black, e_blk);
    chk("width", out_width, e_w);
    chk("oor", out_oor, e_oor);
    chk("oct", out_oct, e_oct);
    chk("in_ready_in_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_pitch = 6'($urandom);
      chk("hold_valid", out_valid, 1);
      chk("hold_pos", out_pos, e_pos);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_pos_held", out_pos, e_pos);
  endtask

  initial begin
    int e, tmin, tmax, t, p, w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pitch = '0; in_trans = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pos", out_pos, 640);
    chk("rst_black", out_black, 0);
    chk("rst_width", out_width, 22);
    chk("rst_oor", out_oor, 0);
    chk("rst_oct", out_oct, 0);

    // Directed cases
    run_req(0, 0, 0);
    run_req(13, 0, 0);
    run_req(47, 0, 0);
    run_req(45, 3, 0);
    run_req(2, -3, 0);
    run_req(26, -2, 0);
    run_req(0, -1, 0);
    run_req(63, 15, 0);
    run_req(11, 0, 10);

    // Reset in the middle of the divider
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    in_valid = 1'b1; in_pitch = 6'd40; in_trans = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pos", out_pos, 640);
    chk("midrst_oor", out_oor, 0);
    repeat (8) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    run_req(40, 0, 0);

    // Reset while a result waits in DONE
    in_valid = 1'b1; in_pitch = 6'd5; in_trans = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("donerst_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_pos", out_pos, 640);

    // Random legal pitches with random consumer delay
    for (int n = 0; n < 30; n++) begin
      e    = $urandom_range(0, 47);
      tmin = (e - 63 > -16) ? e - 63 : -16;
      tmax = (e < 15) ? e : 15;
      t    = tmin + int'($urandom_range(0, tmax - tmin));
      run_req(e - t, t, $urandom_range(0, 3));
    end
    // Fully random requests, including out-of-range ones
    for (int n = 0; n < 15; n++) begin
      p = $urandom_range(0, 63);
      t = int'($urandom_range(0, 31)) - 16;
      run_req(p, t, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
